// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: aligns to the COM symbol in an MSB-first bit stream and,
// once locked, emits every received byte with a one-cycle strobe.
module serial_paralelo #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_LOCK   = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] ComLock = 4'(COM_LOCK);

  typedef enum logic [1:0] {
    StHunt   = 2'b00,
    StVerify = 2'b01,
    StLocked = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  logic       boundary;
  logic       is_com;
  logic [3:0] com_inc;

  // Matching on sr_d means the byte is judged on the same edge that samples its LSB.
  assign sr_d     = {sr_q[6:0], data_in};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_com   = (sr_d == COM_SYMBOL);
  assign com_inc  = (com_cnt_q == 4'hF) ? com_cnt_q : com_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;

    case (state_q)
      StHunt: begin
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = (ComLock == 4'd1) ? StLocked : StVerify;
        end
      end

      StVerify: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_inc;
            if (com_inc == ComLock) begin
              state_d = StLocked;
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = StHunt;
          end
        end
      end

      StLocked: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d   = sr_d;
          valid_d  = ~is_com;
          strobe_d = 1'b1;
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase
  end

  assign active_d = (state_d == StLocked);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q   <= StHunt;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule
